interrupt_controller: RTL

- Arbitrates the two interrupt sources of the game processor: the internal system timer and keyboard key events.
- Presents a prioritized 2-bit request on `INT_IRQ` and runs the IACK/IEND handshake with the processor.
- Sits directly upstream of the game processor, driving its `INT_IRQ` input and consuming its `INT_IACK`/`INT_IEND` outputs.
- Contains the timer tick divider, so the processor needs no timebase of its own.

---
 rtl/intc_pkg.sv | 22 ++
 rtl/intc_timer_div.sv | 28 ++
 rtl/interrupt_controller.sv | 101 ++++++++++
 3 files changed

// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: request codes, FSM state
// type and counter widths.
package intc_pkg;

  // Request codes presented on INT_IRQ (2'b10 is never driven)
  localparam logic [1:0] IRQ_TIMER = 2'b00;
  localparam logic [1:0] IRQ_KBD   = 2'b01;
  localparam logic [1:0] IRQ_NONE  = 2'b11;

  // Handshake FSM: waiting for IACK, or servicing until IEND
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Width of the dropped-keyboard-event counter
  localparam int OVR_W = 8;

  // Width of the system timer divider
  localparam int DIV_W = 24;

endpackage

// File: rtl/intc_timer_div.sv
// System timer divider: counts 0..TIMER_DIV-1 and pulses tick for one cycle
// on the wrap cycle. TIMER_DIV legal range is 2..2^24.
module intc_timer_div
  import intc_pkg::*;
#(
  parameter int TIMER_DIV = 833333
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(TIMER_DIV - 1);

  logic [DIV_W-1:0] cnt;

  assign tick = (cnt == LAST);

  // Free-running divider, wraps to 0 on the tick cycle
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller for the game processor: arbitrates the system timer
// (high priority) and keyboard events, presents a request code on INT_IRQ and
// runs the IACK/IEND handshake.
// Optional feature: define INTC_OVERRUN_CNT_EN to add the saturating
// OVERRUN_COUNT port counting coalesced (dropped) keyboard events.
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int TIMER_DIV = 833333
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             PROC_ENABLE,
  input  logic             KBD_STROBE,
  output logic [1:0]       INT_IRQ,
  input  logic             INT_IACK,
  input  logic             INT_IEND,
  output logic             INT_BUSY
`ifdef INTC_OVERRUN_CNT_EN
  ,
  output logic [OVR_W-1:0] OVERRUN_COUNT
`endif
);

  state_t     state;
  logic       pend_tmr;
  logic       pend_kbd;
  logic       en_q;       // registered PROC_ENABLE, keeps INT_IRQ free of input paths
  logic       tick;
  logic       ack;
  logic       clr_tmr;
  logic       clr_kbd;
  logic [1:0] irq_sel;

  intc_timer_div #(
    .TIMER_DIV(TIMER_DIV)
  ) u_timer_div (
    .clk  (CLK),
    .rst_n(RESET_N),
    .tick (tick)
  );

  // Priority select and output decode from registered state only
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    irq_sel = IRQ_NONE;
    if (pend_tmr)      irq_sel = IRQ_TIMER;
    else if (pend_kbd) irq_sel = IRQ_KBD;
    INT_IRQ = (state == IDLE && en_q) ? irq_sel : IRQ_NONE;
  end

  assign INT_BUSY = (state == BUSY);

  // An acknowledge counts only against a presented request while enabled
  assign ack     = INT_IACK && PROC_ENABLE && (INT_IRQ != IRQ_NONE);
  assign clr_tmr = ack && (INT_IRQ == IRQ_TIMER);
  assign clr_kbd = ack && (INT_IRQ == IRQ_KBD);

  // Pending flags: a set wins over a same-cycle clear, repeated sets coalesce
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pend_tmr <= 1'b0;
      pend_kbd <= 1'b0;
    end else begin
      pend_tmr <= (pend_tmr & ~clr_tmr) | tick;
      pend_kbd <= (pend_kbd & ~clr_kbd) | KBD_STROBE;
    end
  end

  // Handshake FSM; a disabled processor abandons any service in progress
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      en_q  <= 1'b0;
    end else begin
      en_q <= PROC_ENABLE;
      if (!PROC_ENABLE) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE:    if (ack)      state <= BUSY;
          BUSY:    if (INT_IEND) state <= IDLE;
          default:               state <= IDLE;
        endcase
      end
    end
  end

`ifdef INTC_OVERRUN_CNT_EN
  // Count keyboard events absorbed by an already-pending flag, saturating
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      OVERRUN_COUNT <= '0;
    end else if (KBD_STROBE && pend_kbd && !clr_kbd && (OVERRUN_COUNT != '1)) begin
      OVERRUN_COUNT <= OVERRUN_COUNT + 1'b1;
    end
  end
`endif

endmodule
